// File: rtl/servo_osc_pkg.sv
// Shared constants, types and helpers for the twin-servo sweep generator.
// The build option SERVO_OSC_MIRROR_EN is consumed by servo_osc.sv.
package servo_osc_pkg;

  localparam int DEF_PRESCALE = 12;
  localparam int DEF_FRAME_US = 20000;
  localparam int DEF_MIN_US   = 1000;
  localparam int DEF_MAX_US   = 2000;
  localparam int DEF_STEP_US  = 10;

  // Bits needed to hold any value 0..frame_us (pulse widths never exceed the frame).
  function automatic int width_bits(input int frame_us);
    return $clog2(frame_us + 1);
  endfunction

  typedef logic [width_bits(DEF_FRAME_US)-1:0] width_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } sweep_e;

  function automatic bit params_ok(input int prescale, input int frame_us,
                                   input int min_us, input int max_us,
                                   input int step_us);
    return (prescale >= 1) && (min_us < max_us) && (max_us < frame_us) && (step_us >= 1);
  endfunction

endpackage

// File: rtl/servo_osc_if.sv
// Output bundle of servo_osc: the two PWM lines, the direction LED and the sweep state.
// valid/ready: none -- every signal is a free-running registered level, sampled at will.
interface servo_osc_if;
  import servo_osc_pkg::*;

  logic   s0;
  logic   s1;
  logic   led0;
  sweep_e state;

  modport master (output s0, output s1, output led0, output state);
  modport slave  (input  s0, input  s1, input  led0, input  state);

endinterface

// File: rtl/servo_osc_pwm.sv
// One registered PWM output: high while the frame position is below the width.
module servo_pwm #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] frame_us,
  input  logic [W-1:0] width,
  output logic         pwm
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pwm <= 1'b0;
    else       pwm <= (frame_us < width);
  end

endmodule

// File: rtl/servo_osc.sv
// Twin-servo sweep generator: prescaler, frame counter, UP/DOWN sweep FSM, LED.
// Define SERVO_OSC_MIRROR_EN to drive servo 1 in the opposite direction to servo 0.
module servo_osc
  import servo_osc_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int FRAME_US = DEF_FRAME_US,
  parameter int MIN_US   = DEF_MIN_US,
  parameter int MAX_US   = DEF_MAX_US,
  parameter int STEP_US  = DEF_STEP_US
) (
  input  logic   clk,
  input  logic   rstn,
  output logic   s0,
  output logic   s1,
  output logic   led0,
  output sweep_e state
);

  localparam int W  = width_bits(FRAME_US);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  if (!params_ok(PRESCALE, FRAME_US, MIN_US, MAX_US, STEP_US)) begin : g_bad_params
    $error("servo_osc: need PRESCALE>=1, MIN_US<MAX_US<FRAME_US, STEP_US>=1");
  end

  logic [PW-1:0] pre;
  logic          tick;
  logic          wrap;
  logic [W-1:0]  frame_us;
  logic [W-1:0]  width0;
  logic [W-1:0]  width0_n;
  logic [W-1:0]  width1;
  sweep_e        state_n;
  logic          led_n;

  assign tick = (pre == PW'(PRESCALE - 1));
  assign wrap = tick && (frame_us == W'(FRAME_US - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     frame_us <= '0;
    else if (wrap) frame_us <= '0;
    else if (tick) frame_us <= frame_us + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= UP;
      width0 <= W'(MIN_US);
      led0   <= 1'b0;
    end else begin
      state  <= state_n;
      width0 <= width0_n;
      led0   <= led_n;
    end
  end

  // Compare in 32 bits so width0+STEP_US cannot wrap; the clamp catches non-integer spans.
  always_comb begin
    state_n  = state;
    width0_n = width0;
    led_n    = led0;
    if (wrap) begin
      case (state)
        UP: begin
          if (32'(width0) + 32'(STEP_US) >= 32'(MAX_US)) begin
            width0_n = W'(MAX_US);
            state_n  = DOWN;
            led_n    = ~led0;
          end else begin
            width0_n = width0 + W'(STEP_US);
          end
        end
        DOWN: begin
          if (32'(width0) <= 32'(MIN_US + STEP_US)) begin
            width0_n = W'(MIN_US);
            state_n  = UP;
            led_n    = ~led0;
          end else begin
            width0_n = width0 - W'(STEP_US);
          end
        end
      endcase
    end
  end

`ifdef SERVO_OSC_MIRROR_EN
  assign width1 = W'(MIN_US + MAX_US) - width0;
`else
  assign width1 = width0;
`endif

  servo_pwm #(.W(W)) u_pwm0 (
    .clk      (clk),
    .rstn     (rstn),
    .frame_us (frame_us),
    .width    (width0),
    .pwm      (s0)
  );

  servo_pwm #(.W(W)) u_pwm1 (
    .clk      (clk),
    .rstn     (rstn),
    .frame_us (frame_us),
    .width    (width1),
    .pwm      (s1)
  );

endmodule

// File: tb/tb_servo_osc.sv
// Bench for servo_osc: default, small (STEP 2) and clamping (STEP 3) instances
// compared every cycle against a frame-level sweep model.
module tb_servo_osc;
  import servo_osc_pkg::*;

  localparam int NF = 400;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  servo_osc_if if_d ();
  servo_osc_if if_s ();
  servo_osc_if if_c ();

  servo_osc dut_d (
    .clk(clk), .rstn(rstn), .s0(if_d.s0), .s1(if_d.s1), .led0(if_d.led0), .state(if_d.state)
  );

  servo_osc #(.PRESCALE(2), .FRAME_US(20), .MIN_US(4), .MAX_US(8), .STEP_US(2)) dut_s (
    .clk(clk), .rstn(rstn), .s0(if_s.s0), .s1(if_s.s1), .led0(if_s.led0), .state(if_s.state)
  );

  servo_osc #(.PRESCALE(2), .FRAME_US(20), .MIN_US(4), .MAX_US(8), .STEP_US(3)) dut_c (
    .clk(clk), .rstn(rstn), .s0(if_c.s0), .s1(if_c.s1), .led0(if_c.led0), .state(if_c.state)
  );

  int checks = 0;
  int errors = 0;
  int c      = 0;
  int dhigh  = 0;

  int ws [NF];
  int wc [NF];
  bit ls [NF];
  bit lc [NF];

  logic hs0 [241];
  logic hs1 [241];
  logic hc0 [241];
  logic hled[241];

  // Width (or LED level) after k frame wraps, straight from the sweep rules.
  function automatic int sweep(input int mn, input int mx, input int st, input int k,
                               input bit want_led);
    int w  = mn;
    bit up = 1'b1;
    bit l  = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (up) begin
        if (w + st >= mx) begin w = mx; up = 1'b0; l = ~l; end
        else w = w + st;
      end else begin
        if (w <= mn + st) begin w = mn; up = 1'b1; l = ~l; end
        else w = w - st;
      end
    end
    return want_led ? int'(l) : w;
  endfunction

  // Output after edge c reflects the counters during cycle c-1.
  function automatic logic exp_pwm(input int cyc, input int p, input int f, input int width);
    int prev = cyc - 1;
    return ((prev / p) % f) < width;
  endfunction

  function automatic int mirror(input int mn, input int mx, input int w);
`ifdef SERVO_OSC_MIRROR_EN
    return mn + mx - w;
`else
    return w + 0 * (mn + mx);
`endif
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s c=%0d observed %b expected %b", tag, c, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    int ks, kl, wd;
    @(posedge clk);
    c++;
    @(negedge clk);
    ks = (c - 1) / 40;
    kl = c / 40;
    wd = sweep(1000, 2000, 10, (c - 1) / 240000, 1'b0);
    chk1("s.s0",   if_s.s0,   exp_pwm(c, 2, 20, ws[ks]));
    chk1("s.s1",   if_s.s1,   exp_pwm(c, 2, 20, mirror(4, 8, ws[ks])));
    chk1("s.led0", if_s.led0, ls[kl]);
    chk1("c.s0",   if_c.s0,   exp_pwm(c, 2, 20, wc[ks]));
    chk1("c.s1",   if_c.s1,   exp_pwm(c, 2, 20, mirror(4, 8, wc[ks])));
    chk1("c.led0", if_c.led0, lc[kl]);
    chk1("d.s0",   if_d.s0,   exp_pwm(c, 12, 20000, wd));
    chk1("d.s1",   if_d.s1,   exp_pwm(c, 12, 20000, mirror(1000, 2000, wd)));
    chk1("d.led0", if_d.led0, 1'(sweep(1000, 2000, 10, c / 240000, 1'b1)));
    if (if_d.s0 === 1'b1) dhigh++;
    if (c <= 240) begin
      hs0[c]  = if_s.s0;
      hs1[c]  = if_s.s1;
      hc0[c]  = if_c.s0;
      hled[c] = if_s.led0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, ".d.s0"}, if_d.s0, 1'b0);
    chk1({tag, ".d.s1"}, if_d.s1, 1'b0);
    chk1({tag, ".d.led0"}, if_d.led0, 1'b0);
    chk1({tag, ".s.s0"}, if_s.s0, 1'b0);
    chk1({tag, ".s.s1"}, if_s.s1, 1'b0);
    chk1({tag, ".s.led0"}, if_s.led0, 1'b0);
    chk1({tag, ".c.s0"}, if_c.s0, 1'b0);
    chk1({tag, ".c.s1"}, if_c.s1, 1'b0);
    chk1({tag, ".c.led0"}, if_c.led0, 1'b0);
  endtask

  // Asynchronous reset landing mid-cycle, held n cycles, released on a falling edge.
  task automatic do_reset(input int n);
    #2 rstn = 1'b0;
    #1 check_zero("arst");
    repeat (n) @(negedge clk);
    rstn  = 1'b1;
    c     = 0;
    dhigh = 0;
  endtask

  function automatic int sum_hi(input int which, input int f);
    int s = 0;
    for (int i = f * 40 + 1; i <= f * 40 + 40; i++) begin
      if (which == 0 && hs0[i] === 1'b1) s++;
      if (which == 1 && hs1[i] === 1'b1) s++;
      if (which == 2 && hc0[i] === 1'b1) s++;
    end
    return s;
  endfunction

  int exp_s0 [6] = '{8, 12, 16, 12, 8, 12};
`ifdef SERVO_OSC_MIRROR_EN
  int exp_s1 [5] = '{16, 12, 8, 12, 16};
`else
  int exp_s1 [5] = '{8, 12, 16, 12, 8};
`endif
  int exp_c0 [5] = '{8, 14, 16, 10, 8};

  initial begin
    int rise, fall, r;
    for (int k = 0; k < NF; k++) begin
      ws[k] = sweep(4, 8, 2, k, 1'b0);
      wc[k] = sweep(4, 8, 3, k, 1'b0);
      ls[k] = 1'(sweep(4, 8, 2, k, 1'b1));
      lc[k] = 1'(sweep(4, 8, 3, k, 1'b1));
    end

    repeat (5) @(negedge clk);
    check_zero("rst");
    rstn = 1'b1;
    c    = 0;

    repeat (12100) step();
    chkn("d.high_time", dhigh, 12000);

    for (int f = 0; f < 6; f++) chkn($sformatf("s.s0.high[%0d]", f), sum_hi(0, f), exp_s0[f]);
    for (int f = 0; f < 5; f++) chkn($sformatf("s.s1.high[%0d]", f), sum_hi(1, f), exp_s1[f]);
    for (int f = 0; f < 5; f++) chkn($sformatf("c.s0.high[%0d]", f), sum_hi(2, f), exp_c0[f]);
    for (int f = 1; f < 6; f++) begin
      chk1($sformatf("s.s0.frame_start[%0d]", f), hs0[f * 40 + 1], 1'b1);
      chk1($sformatf("s.s0.frame_end[%0d]", f), hs0[f * 40], 1'b0);
    end

    rise = -1;
    fall = -1;
    for (int i = 1; i <= 240; i++) begin
      if (rise < 0 && hled[i] === 1'b1) rise = i;
      else if (rise >= 0 && fall < 0 && hled[i] === 1'b0) fall = i;
    end
    chkn("s.led0.rise_cycle", rise, 80);
    chkn("s.led0.fall_cycle", fall, 160);

    do_reset(3);
    r = $urandom_range(3, 10);
    repeat (120 + r) step();
    chk1("mid.s0_high", if_s.s0, 1'b1);
    chk1("mid.led0_high", if_s.led0, 1'b1);
    do_reset($urandom_range(1, 4));
    repeat (200) step();
    chkn("mid.restart_high", sum_hi(0, 0), 8);
    chk1("mid.restart_led0", hled[1], 1'b0);

    repeat (3) begin
      repeat ($urandom_range(50, 600)) step();
      do_reset($urandom_range(1, 3));
    end
    repeat (100) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
